pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register for the 5-stage MIPS core (E/M, M/W, D/E).

---
 rtl/pipe_stage_reg.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the 5-stage MIPS core: carries IR/PC/BD, merged
// exception code, pass-through channels and a selected result, with stall/flush control.
module pipe_stage_reg #(
  parameter int DW       = 32,
  parameter int NCH      = 2,
  parameter int EXC_W    = 5,
  parameter int HILO_SEL = 1,
  parameter int SCNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                int_flush,
  input  logic                valid_in,
  input  logic [DW-1:0]       ir_in,
  input  logic [DW-1:0]       pc_in,
  input  logic                bd_in,
  input  logic [EXC_W-1:0]    exc_in,
  input  logic [EXC_W-1:0]    exc_local,
  input  logic [NCH*DW-1:0]   ch_in,
  input  logic [DW-1:0]       ao_in,
  input  logic [DW-1:0]       hi_in,
  input  logic [DW-1:0]       lo_in,
  input  logic [1:0]          hilo_sel,
  output logic                valid_out,
  output logic [DW-1:0]       ir_out,
  output logic [DW-1:0]       pc_out,
  output logic                bd_out,
  output logic [EXC_W-1:0]    exc_out,
  output logic [NCH*DW-1:0]   ch_out,
  output logic [DW-1:0]       ao_out,
  output logic [SCNT_W-1:0]   stall_cnt
);

  localparam logic [SCNT_W-1:0] SCNT_MAX = '1;

  logic                valid_q, valid_d;
  logic [DW-1:0]       ir_q, ir_d;
  logic [DW-1:0]       pc_q, pc_d;
  logic                bd_q, bd_d;
  logic [EXC_W-1:0]    exc_q, exc_d;
  logic [NCH*DW-1:0]   ch_q, ch_d;
  logic [DW-1:0]       ao_q, ao_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;

  logic [EXC_W-1:0]    exc_merged;
  logic [DW-1:0]       res_sel;

  // The earliest stage's exception wins; a bubble never carries one.
  always_comb begin
    exc_merged = '0;
    if (valid_in) exc_merged = (exc_in != '0) ? exc_in : exc_local;
  end

  if (HILO_SEL != 0) begin : g_hilo
    always_comb begin
      unique case (hilo_sel)
        2'b01:   res_sel = hi_in;
        2'b10:   res_sel = lo_in;
        default: res_sel = ao_in;
      endcase
    end
  end else begin : g_ao
    assign res_sel = ao_in;
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    valid_d = valid_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    ch_d    = ch_q;
    ao_d    = ao_q;
    scnt_d  = scnt_q;
    if (int_flush) begin
      // Interrupt bubble keeps PC and BD so the EPC can be formed downstream.
      valid_d = 1'b0;
      ir_d    = '0;
      pc_d    = pc_in;
      bd_d    = bd_in;
      exc_d   = '0;
      ch_d    = '0;
      ao_d    = '0;
      scnt_d  = '0;
    end else if (flush) begin
      valid_d = 1'b0;
      ir_d    = '0;
      pc_d    = '0;
      bd_d    = 1'b0;
      exc_d   = '0;
      ch_d    = '0;
      ao_d    = '0;
      scnt_d  = '0;
    end else if (stall) begin
      if (scnt_q != SCNT_MAX) scnt_d = scnt_q + 1'b1;
    end else begin
      valid_d = valid_in;
      ir_d    = ir_in;
      pc_d    = pc_in;
      bd_d    = bd_in;
      exc_d   = exc_merged;
      ch_d    = ch_in;
      ao_d    = res_sel;
      scnt_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ir_q    <= '0;
      pc_q    <= '0;
      bd_q    <= 1'b0;
      exc_q   <= '0;
      ch_q    <= '0;
      ao_q    <= '0;
      scnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
      exc_q   <= exc_d;
      ch_q    <= ch_d;
      ao_q    <= ao_d;
      scnt_q  <= scnt_d;
    end
  end

  assign valid_out = valid_q;
  assign ir_out    = ir_q;
  assign pc_out    = pc_q;
  assign bd_out    = bd_q;
  assign exc_out   = exc_q;
  assign ch_out    = ch_q;
  assign ao_out    = ao_q;
  assign stall_cnt = scnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed steps then random cycles, compared
// against a behavioural model; a second instance checks the HILO_SEL=0 result path.
module tb_pipe_stage_reg;
  localparam int DW = 32, NCH = 2, EXC_W = 5, SCNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, stall, flush, int_flush, valid_in, bd_in;
  logic [DW-1:0]     ir_in, pc_in, ao_in, hi_in, lo_in;
  logic [EXC_W-1:0]  exc_in, exc_local;
  logic [NCH*DW-1:0] ch_in;
  logic [1:0]        hilo_sel;

  logic              valid_out, bd_out;
  logic [DW-1:0]     ir_out, pc_out, ao_out;
  logic [EXC_W-1:0]  exc_out;
  logic [NCH*DW-1:0] ch_out;
  logic [SCNT_W-1:0] stall_cnt;

  logic              valid_out0, bd_out0;
  logic [DW-1:0]     ir_out0, pc_out0, ao_out0;
  logic [EXC_W-1:0]  exc_out0;
  logic [NCH*DW-1:0] ch_out0;
  logic [SCNT_W-1:0] stall_cnt0;

  pipe_stage_reg #(.DW(DW), .NCH(NCH), .EXC_W(EXC_W), .HILO_SEL(1), .SCNT_W(SCNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .int_flush(int_flush),
    .valid_in(valid_in), .ir_in(ir_in), .pc_in(pc_in), .bd_in(bd_in), .exc_in(exc_in),
    .exc_local(exc_local), .ch_in(ch_in), .ao_in(ao_in), .hi_in(hi_in), .lo_in(lo_in),
    .hilo_sel(hilo_sel), .valid_out(valid_out), .ir_out(ir_out), .pc_out(pc_out),
    .bd_out(bd_out), .exc_out(exc_out), .ch_out(ch_out), .ao_out(ao_out),
    .stall_cnt(stall_cnt));

  pipe_stage_reg #(.DW(DW), .NCH(NCH), .EXC_W(EXC_W), .HILO_SEL(0), .SCNT_W(SCNT_W)) dut_ao (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .int_flush(int_flush),
    .valid_in(valid_in), .ir_in(ir_in), .pc_in(pc_in), .bd_in(bd_in), .exc_in(exc_in),
    .exc_local(exc_local), .ch_in(ch_in), .ao_in(ao_in), .hi_in(hi_in), .lo_in(lo_in),
    .hilo_sel(hilo_sel), .valid_out(valid_out0), .ir_out(ir_out0), .pc_out(pc_out0),
    .bd_out(bd_out0), .exc_out(exc_out0), .ch_out(ch_out0), .ao_out(ao_out0),
    .stall_cnt(stall_cnt0));

  int vectors = 0;
  int miscompares = 0;

  // Expected register contents.
  logic              m_valid, m_bd;
  logic [DW-1:0]     m_ir, m_pc, m_ao, m_ao0;
  logic [EXC_W-1:0]  m_exc;
  logic [NCH*DW-1:0] m_ch;
  int                m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_data();
    valid_in  = 1'($urandom);
    ir_in     = $urandom;
    pc_in     = $urandom;
    bd_in     = 1'($urandom);
    exc_in    = ($urandom_range(0, 1) == 0) ? '0 : EXC_W'($urandom);
    exc_local = ($urandom_range(0, 1) == 0) ? '0 : EXC_W'($urandom);
    ch_in     = {$urandom, $urandom};
    ao_in     = $urandom;
    hi_in     = $urandom;
    lo_in     = $urandom;
    hilo_sel  = 2'($urandom);
  endtask

  task automatic clear_ctrl();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; int_flush = 1'b0;
  endtask

  // One clock edge in terms of the behaviour rules, highest priority first.
  task automatic model_edge();
    if (reset) begin
      m_valid = 0; m_ir = 0; m_pc = 0; m_bd = 0; m_exc = 0; m_ch = 0; m_ao = 0; m_ao0 = 0;
      m_cnt = 0;
    end else if (int_flush) begin
      m_valid = 0; m_ir = 0; m_exc = 0; m_ch = 0; m_ao = 0; m_ao0 = 0; m_cnt = 0;
      m_pc = pc_in; m_bd = bd_in;
    end else if (flush) begin
      m_valid = 0; m_ir = 0; m_pc = 0; m_bd = 0; m_exc = 0; m_ch = 0; m_ao = 0; m_ao0 = 0;
      m_cnt = 0;
    end else if (stall) begin
      m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    end else begin
      m_valid = valid_in; m_ir = ir_in; m_pc = pc_in; m_bd = bd_in; m_ch = ch_in;
      if (!valid_in)      m_exc = 0;
      else if (exc_in != 0) m_exc = exc_in;
      else                m_exc = exc_local;
      m_ao  = (hilo_sel == 2'd1) ? hi_in : (hilo_sel == 2'd2) ? lo_in : ao_in;
      m_ao0 = ao_in;
      m_cnt = 0;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".valid"}, 64'(valid_out), 64'(m_valid));
    check({tag, ".ir"},    64'(ir_out),    64'(m_ir));
    check({tag, ".pc"},    64'(pc_out),    64'(m_pc));
    check({tag, ".bd"},    64'(bd_out),    64'(m_bd));
    check({tag, ".exc"},   64'(exc_out),   64'(m_exc));
    check({tag, ".ch"},    ch_out,         m_ch);
    check({tag, ".ao"},    64'(ao_out),    64'(m_ao));
    check({tag, ".ao0"},   64'(ao_out0),   64'(m_ao0));
    check({tag, ".scnt"},  64'(stall_cnt), 64'(m_cnt));
  endtask

  initial begin
    m_cnt = 0;
    clear_ctrl();
    rand_data();
    // Reset with random inputs and random controls.
    reset = 1'b1; stall = 1'b1; int_flush = 1'b1;
    step("rst0");
    rand_data();
    step("rst1");
    check("rst_scnt", 64'(stall_cnt), 64'd0);
    clear_ctrl();

    // Plain load.
    rand_data();
    valid_in = 1'b1; pc_in = 32'h3000; ir_in = 32'h012A4020; ch_in[31:0] = 32'h3008;
    exc_in = '0; exc_local = '0;
    step("load");
    check("load_pc", 64'(pc_out), 64'h3000);
    check("load_ch0", 64'(ch_out[31:0]), 64'h3008);

    // Result selection.
    hilo_sel = 2'b01; hi_in = 32'hDEAD0001; ao_in = 32'd5;
    step("hi");
    check("hi_ao", 64'(ao_out), 64'hDEAD0001);
    check("hi_ao0", 64'(ao_out0), 64'd5);
    hilo_sel = 2'b10; step("lo");
    hilo_sel = 2'b11; step("rsv");

    // Exception merge.
    valid_in = 1'b1; exc_in = '0; exc_local = 5'd12; step("exc_local");
    check("exc_local_v", 64'(exc_out), 64'd12);
    exc_in = 5'd4; step("exc_first");
    check("exc_first_v", 64'(exc_out), 64'd4);
    valid_in = 1'b0; exc_in = '0; step("exc_bubble");
    check("exc_bubble_v", 64'(exc_out), 64'd0);

    // Long stall saturates the counter while inputs keep changing.
    valid_in = 1'b1; exc_in = 5'd3; step("pre_stall");
    stall = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_data();
      step("stall");
    end
    check("stall_sat", 64'(stall_cnt), 64'd255);
    stall = 1'b0; rand_data(); step("unstall");
    check("unstall_cnt", 64'(stall_cnt), 64'd0);

    // Interrupt flush wins over stall and keeps PC/BD.
    stall = 1'b1; step("stall2");
    int_flush = 1'b1; pc_in = 32'h3010; bd_in = 1'b1; valid_in = 1'b1; exc_in = 5'd7;
    step("iflush");
    check("iflush_pc", 64'(pc_out), 64'h3010);
    check("iflush_bd", 64'(bd_out), 64'd1);
    int_flush = 1'b0;
    // Plain flush wins over stall.
    rand_data(); step("pre_flush");
    flush = 1'b1; step("flush");
    check("flush_pc", 64'(pc_out), 64'd0);
    clear_ctrl();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_data();
      reset     = ($urandom_range(0, 99) < 2);
      int_flush = ($urandom_range(0, 99) < 6);
      flush     = ($urandom_range(0, 99) < 6);
      stall     = ($urandom_range(0, 99) < 35);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
